// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan sequencer, the 8x1 multiplexer and the snapshot consumer.
interface mux_scan_ctrl_if;
   logic       start;
   logic [2:0] mux_sel;
   logic       mux_f;
   logic [7:0] word;
   logic       word_valid;
   logic       word_ready;
   logic       busy;

   // Sequencer side
   modport master (
      input  start,
      input  mux_f,
      input  word_ready,
      output mux_sel,
      output word,
      output word_valid,
      output busy
   );

   // Requester / multiplexer / consumer side
   modport slave (
      output start,
      output mux_f,
      output word_ready,
      input  mux_sel,
      input  word,
      input  word_valid,
      input  busy
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the eight inputs of an 8x1 mux in order 0..7, waiting SETTLE_CYCLES after each
// select change, and presents the assembled byte on a valid/ready port.
module mux_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic            clk,
   input logic            rst_n,
   mux_scan_ctrl_if.master bus
);

   localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StHold} state_e;

   state_e     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] word_q, word_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;

   // Every output is a register; no input reaches an output combinationally.
   assign bus.mux_sel    = sel_q;
   assign bus.word       = word_q;
   assign bus.word_valid = valid_q;
   assign bus.busy       = busy_q;

   // State and output registers, cleared asynchronously so an aborted scan leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel_q   <= 3'd0;
         cnt_q   <= 4'd0;
         word_q  <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and next-output decode for the scan sequence.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = valid_q;
      busy_d  = busy_q;

      case (state_q)
         StIdle: begin
            sel_d   = 3'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            if (bus.start) begin
               word_d  = 8'h00;
               cnt_d   = CntLoad;
               busy_d  = 1'b1;
               state_d = StSettle;
            end
         end

         StSettle: begin
            // Loaded with SETTLE_CYCLES-1, so the dwell here is exactly SETTLE_CYCLES cycles.
            if (cnt_q == 4'd0) begin
               state_d = StSample;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         StSample: begin
            word_d[sel_q] = bus.mux_f;
            if (sel_q == 3'd7) begin
               valid_d = 1'b1;
               state_d = StHold;
            end else begin
               sel_d   = sel_q + 3'd1;
               cnt_d   = CntLoad;
               state_d = StSettle;
            end
         end

         StHold: begin
            if (bus.word_ready) begin
               valid_d = 1'b0;
               sel_d   = 3'd0;
               if (bus.start) begin
                  // Handshake and new request on the same edge: restart with no idle cycle.
                  word_d  = 8'h00;
                  cnt_d   = CntLoad;
                  state_d = StSettle;
               end else begin
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
            sel_d   = 3'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl with a behavioural 8x1 mux and a result scoreboard.
module tb_mux_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] mux_in;   // bit k is mux input I[k]
   int         n_checks;
   int         n_pass;
   logic [7:0] exp_q[$];

   mux_scan_ctrl_if bus ();

   mux_scan_ctrl #(
      .SETTLE_CYCLES(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural 8x1 multiplexer
   assign bus.mux_f = mux_in[bus.mux_sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if something hangs despite the bounded waits.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time expired, got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until word_valid is seen; lat is the edge count since the call, -1 if not seen.
   task automatic wait_valid(input int bound, output int lat);
      lat = -1;
      for (int i = 1; i <= bound; i++) begin
         step();
         if (bus.word_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic wait_sel(input logic [2:0] sel, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (bus.mux_sel === sel) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.word_ready = 1'b0;
      mux_in = 8'h00;
      repeat (3) step();
      n_checks++;
      if ({bus.mux_sel, bus.word, bus.word_valid, bus.busy} !== {3'd0, 8'h00, 1'b0, 1'b0})
         $display("FAIL reset_held: got sel=%0d word=%h valid=%b busy=%b want 0/00/0/0",
                  bus.mux_sel, bus.word, bus.word_valid, bus.busy);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.start = 1'b0;
         step();
         n_checks++;
         if ({bus.mux_sel, bus.word, bus.word_valid, bus.busy} !== {3'd0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_idle[%0d]: got sel=%0d word=%h valid=%b busy=%b want 0/00/0/0",
                     i, bus.mux_sel, bus.word, bus.word_valid, bus.busy);
         else n_pass++;
      end
   endtask

   task automatic test_basic_scan();
      logic [7:0] exp;
      mux_in = 8'hCA;
      bus.word_ready = 1'b1;
      bus.start = 1'b1;
      exp_q.push_back(mux_in);
      step();
      bus.start = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", bus.busy);
      else n_pass++;
      // After edge N+t the select is t/2 and no valid yet.
      for (int t = 0; t < 16; t++) begin
         if (t != 0) step();
         n_checks++;
         if (bus.mux_sel !== 3'(t / 2) || bus.word_valid !== 1'b0)
            $display("FAIL basic_step[%0d]: got sel=%0d valid=%b want sel=%0d valid=0",
                     t, bus.mux_sel, bus.word_valid, t / 2);
         else n_pass++;
      end
      step();
      n_checks++;
      if (bus.word_valid !== 1'b1 || bus.mux_sel !== 3'd7)
         $display("FAIL basic_valid_at_16: got valid=%b sel=%0d want valid=1 sel=7",
                  bus.word_valid, bus.mux_sel);
      else n_pass++;
      exp = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (bus.word !== exp) $display("FAIL basic_word: got %h want %h", bus.word, exp);
      else n_pass++;
      step();
      n_checks++;
      if ({bus.word_valid, bus.busy, bus.mux_sel, bus.word} !== {1'b0, 1'b0, 3'd0, exp})
         $display("FAIL basic_after_handshake: got valid=%b busy=%b sel=%0d word=%h want 0/0/0/%h",
                  bus.word_valid, bus.busy, bus.mux_sel, bus.word, exp);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [7:0] exp;
      int lat;
      mux_in = 8'hCA;
      bus.word_ready = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back(mux_in);
      step();
      bus.start = 1'b0;
      wait_valid(40, lat);
      n_checks++;
      if (lat != 16) $display("FAIL bp_latency: got %0d want 16", lat);
      else n_pass++;
      exp = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (bus.word !== exp) $display("FAIL bp_word: got %h want %h", bus.word, exp);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if ({bus.word_valid, bus.busy, bus.mux_sel, bus.word} !== {1'b1, 1'b1, 3'd7, exp})
            $display("FAIL bp_hold[%0d]: got valid=%b busy=%b sel=%0d word=%h want 1/1/7/%h",
                     i, bus.word_valid, bus.busy, bus.mux_sel, bus.word, exp);
         else n_pass++;
      end
      bus.word_ready = 1'b1;
      step();
      bus.word_ready = 1'b0;
      n_checks++;
      if ({bus.word_valid, bus.busy, bus.mux_sel, bus.word} !== {1'b0, 1'b0, 3'd0, exp})
         $display("FAIL bp_release: got valid=%b busy=%b sel=%0d word=%h want 0/0/0/%h",
                  bus.word_valid, bus.busy, bus.mux_sel, bus.word, exp);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      int lat;
      mux_in = 8'hCA;
      bus.word_ready = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back(mux_in);
      step();
      bus.start = 1'b0;
      wait_valid(40, lat);
      exp = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (lat != 16 || bus.word !== exp)
         $display("FAIL b2b_first: got lat=%0d word=%h want lat=16 word=%h", lat, bus.word, exp);
      else n_pass++;
      step();
      // Handshake plus new request on the same edge.
      mux_in = 8'hFF;
      bus.start = 1'b1;
      bus.word_ready = 1'b1;
      exp_q.push_back(mux_in);
      step();
      bus.start = 1'b0;
      bus.word_ready = 1'b0;
      n_checks++;
      if ({bus.busy, bus.word_valid, bus.mux_sel, bus.word} !== {1'b1, 1'b0, 3'd0, 8'h00})
         $display("FAIL b2b_no_idle: got busy=%b valid=%b sel=%0d word=%h want 1/0/0/00",
                  bus.busy, bus.word_valid, bus.mux_sel, bus.word);
      else n_pass++;
      wait_valid(40, lat);
      n_checks++;
      if (lat != 16) $display("FAIL b2b_latency: got %0d want 16", lat);
      else n_pass++;
      exp = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (bus.word !== exp) $display("FAIL b2b_word: got %h want %h", bus.word, exp);
      else n_pass++;
      bus.word_ready = 1'b1;
      step();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0)
         $display("FAIL b2b_release: got busy=%b valid=%b want 0/0", bus.busy, bus.word_valid);
      else n_pass++;
   endtask

   task automatic test_ignored_start();
      logic [7:0] exp;
      int  t_valid;
      int  n_valid;
      bit  pulsed;
      mux_in = 8'hCA;
      bus.word_ready = 1'b1;
      bus.start = 1'b1;
      exp_q.push_back(mux_in);
      step();
      bus.start = 1'b0;
      t_valid = -1;
      n_valid = 0;
      pulsed = 1'b0;
      exp = 8'h00;
      for (int t = 1; t <= 50; t++) begin
         step();
         bus.start = 1'b0;
         if (!pulsed && bus.mux_sel === 3'd3) begin
            bus.start = 1'b1;
            pulsed = 1'b1;
         end
         if (bus.word_valid === 1'b1) begin
            n_valid++;
            if (t_valid < 0) begin
               t_valid = t;
               exp = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
               n_checks++;
               if (bus.word !== exp) $display("FAIL ign_word: got %h want %h", bus.word, exp);
               else n_pass++;
            end
         end
      end
      bus.start = 1'b0;
      n_checks++;
      if (t_valid != 16) $display("FAIL ign_latency: got %0d want 16", t_valid);
      else n_pass++;
      n_checks++;
      if (n_valid != 1) $display("FAIL ign_valid_count: got %0d want 1", n_valid);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.word !== exp)
         $display("FAIL ign_end_idle: got busy=%b word=%h want 0/%h", bus.busy, bus.word, exp);
      else n_pass++;
   endtask

   task automatic test_reset_mid_scan();
      logic [7:0] exp;
      int  lat;
      bit  ok;
      int  n_valid;
      mux_in = 8'hCA;
      bus.word_ready = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_sel(3'd5, 40, ok);
      n_checks++;
      if (!ok) $display("FAIL rst_mid_reach5: got sel=%0d want 5", bus.mux_sel);
      else n_pass++;
      // Assert reset between edges; outputs must clear before the next edge.
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.mux_sel, bus.word, bus.word_valid, bus.busy} !== {3'd0, 8'h00, 1'b0, 1'b0})
         $display("FAIL rst_mid_async: got sel=%0d word=%h valid=%b busy=%b want 0/00/0/0",
                  bus.mux_sel, bus.word, bus.word_valid, bus.busy);
      else n_pass++;
      repeat (2) step();
      rst_n = 1'b1;
      n_valid = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.word_valid === 1'b1) n_valid++;
      end
      n_checks++;
      if (n_valid != 0 || bus.busy !== 1'b0)
         $display("FAIL rst_mid_no_valid: got valid_count=%0d busy=%b want 0/0", n_valid, bus.busy);
      else n_pass++;
      mux_in = 8'h35;
      bus.start = 1'b1;
      exp_q.push_back(mux_in);
      step();
      bus.start = 1'b0;
      wait_valid(40, lat);
      n_checks++;
      if (lat != 16) $display("FAIL rst_mid_rescan_latency: got %0d want 16", lat);
      else n_pass++;
      exp = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (bus.word !== exp) $display("FAIL rst_mid_rescan_word: got %h want %h", bus.word, exp);
      else n_pass++;
      step();
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      test_reset();
      test_basic_scan();
      test_backpressure();
      test_back_to_back();
      test_ignored_start();
      test_reset_mid_scan();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream and downstream of the 8x1 multiplexer. It drives the multiplexer's 3-bit select, waits a programmable settle time, and samples the multiplexer output for each of the eight channels in order 0..7. It then presents the assembled 8-bit snapshot on a valid/ready output port, turning the combinational channel selector into a scanned parallel capture stage.

## Interface
- SETTLE_CYCLES, default 1: cycles `mux_sel` is held stable before `mux_f` is sampled; legal range 1..15.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset; synchronous de-assertion is the integrator's responsibility.
- start  input  1  scan request; sampled only in IDLE (and HOLD, see below).
- mux_sel  output  3  drives the multiplexer select S; registered.
- mux_f  input  1  multiplexer output F.
- word  output  8  captured snapshot; `word[k]` = `mux_f` sampled while `mux_sel`=k.
- word_valid  output  1  snapshot complete and stable.
- word_ready  input  1  consumer accepts `word` when high with `word_valid` at a rising edge.
- busy  output  1  high from scan start until handshake completes (high in SETTLE, SAMPLE, HOLD).

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - `mux_sel`=0, `word_valid`=0, `busy`=0.
  - `start`=1 -> `mux_sel`<=0, `word`<=0, settle counter<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0, go to SAMPLE.
  - Total SETTLE dwell is exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - `word[mux_sel]`<=`mux_f`.
  - If `mux_sel`==7 -> go to HOLD, `word_valid`<=1.
  - Else `mux_sel`<=`mux_sel`+1, reload counter, go to SETTLE.
- HOLD:
  - `word` and `word_valid` are frozen.
  - `mux_sel` stays at 7.
  - `word_ready`=1 -> `word_valid`<=0, go to IDLE (`mux_sel`<=0). `word` retains its value.
  - `word_ready`=1 and `start`=1 together -> skip IDLE: `word_valid`<=0, `word`<=0, `mux_sel`<=0, go to SETTLE.
- `start` is ignored in SETTLE and SAMPLE; there is no queuing.
- `mux_sel` never wraps within a scan; the counter is 3 bits and saturates at 7 in HOLD.
- Reset asserted mid-scan:
  - Immediately forces IDLE and all outputs to reset values.
  - The partial word is discarded.
  - No `word_valid` pulse is produced for the aborted scan.

## Timing
- Reset values: `mux_sel`=3'd0, `word`=8'h00, `word_valid`=0, `busy`=0, state IDLE.
- All outputs are registered; there is no combinational path from any input to any output.
- `mux_f` is sampled at the rising edge that ends the SAMPLE cycle. By then `mux_sel` has been stable for SETTLE_CYCLES+1 edges.
- Per-channel cost is SETTLE_CYCLES+1 cycles.
- Latency: with `start` accepted at edge N, `word_valid` rises at edge N+8*(SETTLE_CYCLES+1). For SETTLE_CYCLES=1 this is N+16.
- `busy` rises at edge N and falls at the handshake edge.
- Back-to-back scans via simultaneous `word_ready`/`start` in HOLD lose no cycle: the next SETTLE begins at the handshake edge.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release; toggle `start`=0 -> all outputs at reset values, `mux_sel` stays 0.
- Basic scan: mux `I`=8'b01010011 (`I[0]` leftmost), SETTLE_CYCLES=1, pulse `start`, `word_ready`=1 -> `mux_sel` steps 0..7 every 2 cycles; `word`=8'hCA and `word_valid`=1 exactly 16 edges after start; `word_valid` drops next edge.
- Backpressure: same stimulus, `word_ready`=0 for 10 cycles after valid -> `word`=8'hCA and `word_valid`=1 held stable for all 10 cycles, `busy`=1; release -> IDLE.
- Back-to-back: in HOLD, assert `start` and `word_ready` together with `I` changed to 8'hFF -> no idle cycle; second `word`=8'hFF 16 edges later.
- Ignored start: pulse `start` again at `mux_sel`=3 -> scan unaffected, single `word_valid`, result still 8'hCA.
- Reset mid-scan: assert `rst_n`=0 while `mux_sel`=5 -> outputs are reset asynchronously before the next edge; no `word_valid`; a new `start` completes a full 16-cycle scan.
